// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch stage: PC-select codes and fetch FSM states.
package fetch_pc_pkg;

    // Controller PC-select codes, {j_c, branch_c}; 2'b11 is decoded as a jump.
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_VALID = 2'd2
    } fetch_state_t;

    // A commit is "taken" whenever the controller asks for anything but pc+4.
    function automatic logic is_taken(input logic [1:0] sel);
        return sel != PCSEL_SEQ;
    endfunction

endpackage

// File: rtl/fetch_pc_pc_next_calc.sv
// pc_next_calc: combinational next-PC selection (sequential, branch, jump).
// Jump has priority over branch, so select 2'b11 behaves as a jump.
module pc_next_calc
    import fetch_pc_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      pc_next_c,
    input  logic [15:0]     br_imm,
    input  logic [25:0]     j_addr,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;
    logic [PC_W-1:0] br_off;

    assign pc_plus4  = pc + PC_W'(4);
    // Signed word offset turned into a byte offset; addition wraps mod 2^PC_W.
    assign br_off    = {{(PC_W-18){br_imm[15]}}, br_imm, 2'b00};
    assign br_target = pc_plus4 + br_off;

    // Jump keeps the upper region bits of pc+4 above the 28-bit jump field.
    generate
        if (PC_W > 28) begin : g_j_region
            assign j_target = {pc_plus4[PC_W-1:28], j_addr, 2'b00};
        end else begin : g_j_flat
            assign j_target = {j_addr, 2'b00};
        end
    endgenerate

    // Select the next PC; jump bit dominates the branch bit.
    always_comb begin
        next_pc = pc_plus4;
        if ((pc_next_c & PCSEL_J) != 2'b00) begin
            next_pc = j_target;
        end else if (pc_next_c == PCSEL_BR) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: program counter and instruction fetch stage.
// Fetches one instruction over a req/ack handshake, holds it while decode
// stalls, and commits the controller-selected next PC when the stall clears.
// Optional build macro FETCH_PERF_EN adds retired/taken commit counters.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_next_c,
    input  logic [15:0]     br_imm,
    input  logic [25:0]     j_addr,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     retired_cnt,
    output logic [31:0]     taken_cnt,
`endif
    output logic [PC_W-1:0] pc_plus4
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg;
    logic [31:0]     instr_reg;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pc_plus4_w;
    logic            commit;
    logic            capture;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
        .pc        (pc_reg),
        .pc_next_c (pc_next_c),
        .br_imm    (br_imm),
        .j_addr    (j_addr),
        .pc_plus4  (pc_plus4_w),
        .next_pc   (next_pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= F_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus capture/commit strobes; ack is only honoured in FETCH.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            F_IDLE: begin
                state_next = F_FETCH;
            end
            F_FETCH: begin
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = F_VALID;
                end
            end
            F_VALID: begin
                if (!stall) begin
                    commit     = 1'b1;
                    state_next = F_FETCH;
                end
            end
            default: begin
                state_next = F_IDLE;
            end
        endcase
    end

    // PC and instruction registers; every PC load is forced word-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC & ALIGN_MASK;
            instr_reg <= '0;
        end else begin
            if (commit) begin
                pc_reg <= next_pc & ALIGN_MASK;
            end
            if (capture) begin
                instr_reg <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] retired_cnt_reg;
    logic [31:0] taken_cnt_reg;

    // Commit counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_reg <= '0;
            taken_cnt_reg   <= '0;
        end else if (commit) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
            if (is_taken(pc_next_c)) begin
                taken_cnt_reg <= taken_cnt_reg + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_cnt_reg;
    assign taken_cnt   = taken_cnt_reg;
`endif

    assign imem_req    = (state_reg == F_FETCH);
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = (state_reg == F_VALID);
    assign pc          = pc_reg;
    assign pc_plus4    = pc_plus4_w;

endmodule
